// File: rtl/ps2_keyboard_rx_if.sv
// Key-event bus from the PS/2 receiver to the processor's keyboard inputs.
// The receiver drives it (master); the consumer samples it (slave).
interface ps2_keyboard_rx_if;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       key_release;
  logic       key_extended;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output ps2_key_pressed,
    output ps2_out,
    output key_release,
    output key_extended,
    output parity_error,
    output frame_error
  );

  modport slave (
    input ps2_key_pressed,
    input ps2_out,
    input key_release,
    input key_extended,
    input parity_error,
    input frame_error
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the bus, deserializes 11-bit frames,
// checks parity/stop, and folds F0/E0 prefixes into flags on a single key-event strobe.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  ps2_keyboard_rx_if.master  kbd
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TimeW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             clk_filt_q, clk_filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TimeW-1:0] to_cnt_q, to_cnt_d;
  logic             brk_pend_q, brk_pend_d;
  logic             ext_pend_q, ext_pend_d;
  logic [7:0]       out_q, out_d;
  logic             rel_q, rel_d;
  logic             xt_q, xt_d;
  logic             kp_q, kp_d;
  logic             pe_q, pe_d;
  logic             fe_q, fe_d;
  logic             byte_ok;

  // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s2_q;
        fall       = clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    out_d      = out_q;
    rel_d      = rel_q;
    xt_d       = xt_q;
    kp_d       = 1'b0;
    pe_d       = 1'b0;
    fe_d       = 1'b0;
    byte_ok    = 1'b0;

    if (state_q == StIdle || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (fall) begin
          if (!dat_s2_q) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
      end
      default: begin
        if (fall) begin
          state_d = StIdle;
          if (!dat_s2_q) begin
            fe_d = 1'b1;
          end else if (~^{shift_q, par_q}) begin
            pe_d = 1'b1;
          end else begin
            byte_ok = 1'b1;
          end
        end
      end
    endcase

    if (state_q != StIdle && !fall && to_cnt_q == TimeW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = StIdle;
      to_cnt_d = '0;
      fe_d     = 1'b1;
    end

    // Any error drops pending prefixes so a later byte is never mis-flagged.
    if (fe_d || pe_d) begin
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end

    if (byte_ok) begin
      if (shift_q == CodeBreak) begin
        brk_pend_d = 1'b1;
      end else if (shift_q == CodeExt) begin
        ext_pend_d = 1'b1;
      end else begin
        out_d      = shift_q;
        rel_d      = brk_pend_q;
        xt_d       = ext_pend_q;
        kp_d       = 1'b1;
        brk_pend_d = 1'b0;
        ext_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      out_q      <= 8'h00;
      rel_q      <= 1'b0;
      xt_q       <= 1'b0;
      kp_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      out_q      <= out_d;
      rel_q      <= rel_d;
      xt_q       <= xt_d;
      kp_q       <= kp_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
    end
  end

  assign kbd.ps2_key_pressed = kp_q;
  assign kbd.ps2_out         = out_q;
  assign kbd.key_release     = rel_q;
  assign kbd.key_extended    = xt_q;
  assign kbd.parity_error    = pe_q;
  assign kbd.frame_error     = fe_q;

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver feeding the processor's keyboard inputs (`ps2_key_pressed`, `ps2_out`). It synchronizes and deglitches the raw PS/2 clock and data lines, deserializes 11-bit device-to-host frames, and checks parity and the stop bit. It folds the `F0` (break) and `E0` (extended) prefixes into flags, so the processor sees exactly one strobe per key event.

## Interface
- `FILTER_LEN`, default 4: consecutive identical synchronized samples required before the filtered `ps2_clk` level changes (≥2).
- `TIMEOUT_CYCLES`, default 50000: system clocks without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `clock` input, 1 bit: system clock; all logic on its rising edge.
- `reset` input, 1 bit: one clock; reset is synchronous and active-low (`reset`=0 resets on the next `clock` edge).
- `ps2_clk` input, 1 bit: raw PS/2 clock from the device, asynchronous.
- `ps2_dat` input, 1 bit: raw PS/2 data from the device, asynchronous.
- `ps2_key_pressed` output, 1 bit: one-cycle strobe per completed key event.
- `ps2_out` output, 8 bits: scan code of the last key event; held until the next event.
- `key_release` output, 1 bit: last event was preceded by `F0`; updated with `ps2_out`.
- `key_extended` output, 1 bit: last event was preceded by `E0`; updated with `ps2_out`.
- `parity_error` output, 1 bit: one-cycle strobe when a frame fails odd parity.
- `frame_error` output, 1 bit: one-cycle strobe on a bad start/stop bit or a timeout.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_dat` each pass through a 2-FF synchronizer.
  - `ps2_clk` is additionally filtered: the filtered level changes only after `FILTER_LEN` consecutive equal samples.
  - A fall event is a filtered 1→0 transition. `ps2_dat` (synchronized) is sampled only on fall events.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall event, a sampled 0 goes to DATA with bit count 0. A sampled 1 pulses `frame_error` and stays in IDLE.
  - DATA: each fall event shifts the sample in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on a fall event, capture the parity bit and go to STOP.
  - STOP: on a fall event, check the frame, then return to IDLE.
    - Stop bit 0 → `frame_error` pulse, byte discarded.
    - Otherwise, if data+parity has an even number of ones → `parity_error` pulse, byte discarded.
    - Otherwise the byte is valid and passes to the decoder.
    - Stop-bit errors take priority over parity errors; only one error pulses per frame.
- Timeout: in any non-IDLE state, a counter runs since the last fall event. At `TIMEOUT_CYCLES` with no fall event, go to IDLE and pulse `frame_error`. The counter clears on every fall event and in IDLE.
- Prefix decoder, applied to valid bytes only:
  - `F0` sets `brk_pend`.
  - `E0` sets `ext_pend`.
  - Any other byte:
    - Loads `ps2_out` with the byte.
    - Loads `key_release` from `brk_pend` and `key_extended` from `ext_pend`.
    - Pulses `ps2_key_pressed`.
    - Clears both pend bits.
  - A `parity_error` or `frame_error` clears both pend bits, so a corrupted sequence never produces a mis-flagged event.
- Prefix bytes never strobe `ps2_key_pressed`.

## Timing
- Reset values:
  - All outputs 0; `ps2_out`=`8'h00`.
  - FSM in IDLE; pend bits 0.
  - Synchronizers and filtered clock at 1 (bus idle).
- Fall-event latency: 2 sync cycles + `FILTER_LEN` cycles after the raw `ps2_clk` edge.
- `ps2_key_pressed`, `parity_error` and `frame_error` each assert in the cycle after the clock edge that processes the stop-bit fall event (timeout: the cycle after the counter reaches `TIMEOUT_CYCLES`).
  - Each is high for exactly 1 cycle.
  - They are mutually exclusive.
- `ps2_out`, `key_release` and `key_extended` change in the same cycle `ps2_key_pressed` rises and are stable until the next strobe.
- Reset held low mid-frame: the partial frame is discarded with no strobes. After release, reception resumes at the next start bit.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no fall event.

## Test plan
- Make code: frame `0x1C` (parity bit 0, stop 1) at 12.5 kHz → one `ps2_key_pressed` pulse; `ps2_out`=`0x1C`, `key_release`=0, `key_extended`=0.
- Break sequence: `F0`, then `1C` → exactly one strobe, after the second frame; `ps2_out`=`0x1C`, `key_release`=1, `key_extended`=0.
- Extended break: `E0`, `F0`, `75` → one strobe; `ps2_out`=`0x75`, `key_release`=1, `key_extended`=1. Then `1C` → `key_release`=0, `key_extended`=0.
- Errors:
  - `0x1C` with parity bit 1 → one `parity_error` pulse, no strobe, `ps2_out` unchanged.
  - Stop bit 0 → one `frame_error` pulse only.
  - `F0` followed by a bad frame, then `1C` → `key_release`=0.
- Timeout/reset: stop `ps2_clk` after 5 data bits → `frame_error` after `TIMEOUT_CYCLES`; the next valid `0x29` is received correctly. Pull `reset` low mid-frame → no strobes; the next frame is decoded correctly.
- Glitch: a 2-cycle low pulse on `ps2_clk` (with `FILTER_LEN`=4) during a `0x1C` frame → `ps2_out`=`0x1C`, no errors.
